// File: rtl/pulse_emitter.sv
// Timed pulse generator: queued (center, width) requests become pulses on `signal`
// centred on req_center against a shared free-running counter.
module pulse_emitter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         counter,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_center,
    input  logic [WIDTH-1:0]         req_width,
    output logic                     signal,
    output logic                     done,
    output logic                     late,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] start;
        logic [WIDTH-1:0] stop;
        logic             zero;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_START, HIGH} state_t;

    state_t           state;
    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           incoming;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] cur_start, cur_stop;
    logic [WIDTH-1:0] counter_next, diff;
    logic             push, pop;

    // Start/end are resolved at push time so the pop path is a plain register load.
    always_comb begin
        incoming.start = req_center - (req_width >> 1);
        incoming.stop  = incoming.start + req_width;
        incoming.zero  = (req_width == '0);
    end

    assign head         = mem[rd_ptr];
    assign req_ready    = (count < CW'(DEPTH));
    assign push         = req_valid && req_ready;
    assign pop          = (state == IDLE) && (count != '0);
    assign busy         = (state != IDLE) || (count != '0);
    assign counter_next = counter + WIDTH'(1);
    // Signed distance to start; MSB set means the start is behind us or beyond the horizon.
    assign diff         = cur_start - counter_next;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= incoming;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            signal    <= 1'b0;
            done      <= 1'b0;
            late      <= 1'b0;
            cur_start <= '0;
            cur_stop  <= '0;
        end else begin
            done  <= 1'b0;
            late  <= 1'b0;
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head.zero) begin
                            done <= 1'b1;
                        end else begin
                            cur_start <= head.start;
                            cur_stop  <= head.stop;
                            state     <= WAIT_START;
                        end
                    end
                end
                WAIT_START: begin
                    if (diff == '0) begin
                        signal <= 1'b1;
                        state  <= HIGH;
                    end else if (diff[WIDTH-1]) begin
                        late  <= 1'b1;
                        state <= IDLE;
                    end
                end
                HIGH: begin
                    if (counter_next == cur_stop) begin
                        signal <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
